// File: rtl/game_state_ctrl.sv
// Game-flow controller: owns lives, level and PLAY/DEATH/LEVEL_UP/GAME_OVER sequencing.
// Optional best-level tracking is enabled with the HIGH_SCORE_EN macro.
module game_state_ctrl #(
  parameter logic [1:0]  START_LIVES   = 2'd3,
  parameter logic [3:0]  MAX_LEVEL     = 4'd9,
  parameter logic [23:0] DEATH_TICKS   = 24'd12500000,
  parameter logic [23:0] LEVELUP_TICKS = 24'd6250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Collision,
  input  logic       i_Frog_At_Top,
  input  logic       i_Restart_Req,
  output logic       o_Reset_Frog,
  output logic       o_Freeze,
  output logic       o_Game_Over,
  output logic [3:0] o_Level,
  output logic [1:0] o_Lives,
  output logic [1:0] o_State
`ifdef HIGH_SCORE_EN
  ,
  output logic [3:0] o_Best_Level
`endif
);

  typedef enum logic [1:0] {
    ST_PLAY      = 2'b00,
    ST_DEATH     = 2'b01,
    ST_LEVEL_UP  = 2'b10,
    ST_GAME_OVER = 2'b11
  } state_t;

  state_t      state, state_nx;
  logic [23:0] timer, timer_nx;
  logic [1:0]  lives_nx;
  logic [3:0]  level_nx;
  logic        pulse_nx;

  logic col_cur, col_prev;
  logic top_cur, top_prev;
  logic req_cur, req_prev;
  logic col_evt, top_evt, req_evt;

  // Inputs are sampled once and compared with the previous sample, so events
  // act one edge after they are first seen.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      col_cur  <= 1'b0;
      col_prev <= 1'b0;
      top_cur  <= 1'b0;
      top_prev <= 1'b0;
      req_cur  <= 1'b0;
      req_prev <= 1'b0;
    end else begin
      col_cur  <= i_Collision;
      col_prev <= col_cur;
      top_cur  <= i_Frog_At_Top;
      top_prev <= top_cur;
      req_cur  <= i_Restart_Req;
      req_prev <= req_cur;
    end
  end

  assign col_evt = col_cur & ~col_prev;
  assign top_evt = top_cur & ~top_prev;
  assign req_evt = req_cur & ~req_prev;

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    lives_nx = o_Lives;
    level_nx = o_Level;
    pulse_nx = 1'b0;
    if (req_evt) begin
      state_nx = ST_PLAY;
      timer_nx = '0;
      lives_nx = START_LIVES;
      level_nx = '0;
      pulse_nx = 1'b1;
    end else begin
      case (state)
        ST_PLAY: begin
          if (col_evt) begin
            if (o_Lives > 2'd1) begin
              lives_nx = o_Lives - 2'd1;
              timer_nx = DEATH_TICKS - 24'd1;
              state_nx = ST_DEATH;
            end else begin
              lives_nx = '0;
              state_nx = ST_GAME_OVER;
            end
          end else if (top_evt) begin
            level_nx = (o_Level >= MAX_LEVEL) ? MAX_LEVEL : o_Level + 4'd1;
            timer_nx = LEVELUP_TICKS - 24'd1;
            state_nx = ST_LEVEL_UP;
          end
        end
        ST_DEATH, ST_LEVEL_UP: begin
          // Timer is loaded with N-1, so the zero cycle is the Nth cycle of dwell.
          if (timer == '0) begin
            pulse_nx = 1'b1;
            state_nx = ST_PLAY;
          end else begin
            timer_nx = timer - 24'd1;
          end
        end
        ST_GAME_OVER: begin
          state_nx = ST_GAME_OVER;
        end
        default: begin
          state_nx = ST_PLAY;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state        <= ST_PLAY;
      timer        <= '0;
      o_Lives      <= START_LIVES;
      o_Level      <= '0;
      o_Reset_Frog <= 1'b0;
      o_Freeze     <= 1'b0;
      o_Game_Over  <= 1'b0;
    end else begin
      state        <= state_nx;
      timer        <= timer_nx;
      o_Lives      <= lives_nx;
      o_Level      <= level_nx;
      o_Reset_Frog <= pulse_nx;
      o_Freeze     <= (state_nx != ST_PLAY);
      o_Game_Over  <= (state_nx == ST_GAME_OVER);
    end
  end

  assign o_State = state;

`ifdef HIGH_SCORE_EN
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Best_Level <= '0;
    end else if (o_Level > o_Best_Level) begin
      o_Best_Level <= o_Level;
    end
  end
`else
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: vector table, directed corner sequences
// and randomized stimulus against a rule-level reference model.
module tb_game_state_ctrl;

  logic       clk;
  logic       i_Rst;
  logic       i_Collision;
  logic       i_Frog_At_Top;
  logic       i_Restart_Req;
  logic       o_Reset_Frog;
  logic       o_Freeze;
  logic       o_Game_Over;
  logic [3:0] o_Level;
  logic [1:0] o_Lives;
  logic [1:0] o_State;
`ifdef HIGH_SCORE_EN
  logic [3:0] o_Best_Level;
`endif

  game_state_ctrl #(
    .START_LIVES  (2'd3),
    .MAX_LEVEL    (4'd9),
    .DEATH_TICKS  (24'd8),
    .LEVELUP_TICKS(24'd4)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (i_Rst),
    .i_Collision  (i_Collision),
    .i_Frog_At_Top(i_Frog_At_Top),
    .i_Restart_Req(i_Restart_Req),
    .o_Reset_Frog (o_Reset_Frog),
    .o_Freeze     (o_Freeze),
    .o_Game_Over  (o_Game_Over),
    .o_Level      (o_Level),
    .o_Lives      (o_Lives),
    .o_State      (o_State)
`ifdef HIGH_SCORE_EN
    ,
    .o_Best_Level (o_Best_Level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;

  // Reference model: game mode (0 play, 1 death, 2 level-up, 3 game over),
  // cycles of dwell still owed, and the last two samples of each input.
  int m_mode, m_lives, m_level, m_rem, m_best;
  bit m_pulse;
  bit mc1, mc2, mt1, mt2, mr1, mr2;

  task automatic model_reset();
    m_mode = 0; m_lives = 3; m_level = 0; m_rem = 0; m_best = 0; m_pulse = 0;
    mc1 = 0; mc2 = 0; mt1 = 0; mt2 = 0; mr1 = 0; mr2 = 0;
  endtask

  task automatic model_step(input bit c, input bit t, input bit r);
    bit ce, te, re;
    int old_level;
    ce = mc1 && !mc2;
    te = mt1 && !mt2;
    re = mr1 && !mr2;
    mc2 = mc1; mc1 = c;
    mt2 = mt1; mt1 = t;
    mr2 = mr1; mr1 = r;
    old_level = m_level;
    m_pulse = 0;
    if (re) begin
      m_mode = 0; m_lives = 3; m_level = 0; m_rem = 0; m_pulse = 1;
    end else if (m_mode == 0) begin
      if (ce) begin
        if (m_lives > 1) begin
          m_lives = m_lives - 1; m_mode = 1; m_rem = 8;
        end else begin
          m_lives = 0; m_mode = 3;
        end
      end else if (te) begin
        m_level = (m_level + 1 > 9) ? 9 : m_level + 1;
        m_mode = 2; m_rem = 4;
      end
    end else if (m_mode == 1 || m_mode == 2) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_mode = 0; m_pulse = 1;
      end
    end
    if (old_level > m_best) m_best = old_level;
  endtask

  task automatic check_model(input string name);
    logic [10:0] act, exp;
    bit fz, go;
    fz = (m_mode != 0);
    go = (m_mode == 3);
    act = {o_State, o_Lives, o_Level, o_Reset_Frog, o_Freeze, o_Game_Over};
    exp = {m_mode[1:0], m_lives[1:0], m_level[3:0], m_pulse, fz, go};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got state/lives/level/rf/frz/go=%b required %b at %0t", name, act, exp, $time);
    end
`ifdef HIGH_SCORE_EN
    total++;
    if (o_Best_Level !== m_best[3:0]) begin
      bad++;
      $display("FAIL %s best: got %0d required %0d", name, o_Best_Level, m_best);
    end
`endif
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input bit c, input bit t, input bit r, input bit x);
    @(negedge clk);
    i_Collision = c; i_Frog_At_Top = t; i_Restart_Req = r; i_Rst = x;
    @(posedge clk);
    #1;
    if (i_Rst) model_reset();
    else model_step(c, t, r);
    if (o_Reset_Frog) pulse_cnt++;
    check_model("cycle");
  endtask

  task automatic hit();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
  endtask

  task automatic top();
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
  endtask

  task automatic restart();
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
  endtask

  typedef struct {
    bit c, t, r;
    int st, lives, level;
    bit rf;
  } vec_t;

  vec_t tbl[17];

  initial begin
    bit c, t, r;
    tbl[0]  = '{0, 0, 0, 0, 3, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 3, 0, 0};
    tbl[2]  = '{1, 0, 0, 1, 2, 0, 0};
    tbl[3]  = '{0, 1, 0, 1, 2, 0, 0};
    tbl[4]  = '{0, 1, 0, 1, 2, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 2, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 2, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 2, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 2, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 2, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 2, 0, 1};
    tbl[11] = '{0, 1, 0, 0, 2, 0, 0};
    tbl[12] = '{0, 1, 0, 2, 2, 1, 0};
    tbl[13] = '{0, 0, 1, 2, 2, 1, 0};
    tbl[14] = '{0, 0, 1, 0, 3, 0, 1};
    tbl[15] = '{0, 0, 1, 0, 3, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 3, 0, 0};

    i_Rst = 1'b1; i_Collision = 0; i_Frog_At_Top = 0; i_Restart_Req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_Rst = 1'b0;
    #1;
    check_val("reset lives", o_Lives, 3);
    check_val("reset level", o_Level, 0);
    check_val("reset state", o_State, 0);
    check_val("reset freeze", o_Freeze, 0);
    check_val("reset frog pulse", o_Reset_Frog, 0);
    check_model("reset");

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].c, tbl[i].t, tbl[i].r, 0);
      check_val($sformatf("vec%0d state", i), o_State, tbl[i].st);
      check_val($sformatf("vec%0d lives", i), o_Lives, tbl[i].lives);
      check_val($sformatf("vec%0d level", i), o_Level, tbl[i].level);
      check_val($sformatf("vec%0d pulse", i), o_Reset_Frog, int'(tbl[i].rf));
    end

    // Single death, dwell and respawn
    hit();
    check_val("death lives", o_Lives, 2);
    check_val("death state", o_State, 1);
    check_val("death freeze", o_Freeze, 1);
    pulse_cnt = 0;
    repeat (9) cycle(0, 0, 0, 0);
    check_val("death respawn pulses", pulse_cnt, 1);
    check_val("death back to play", o_State, 0);

    // Run out of lives
    hit();
    repeat (9) cycle(0, 0, 0, 0);
    hit();
    check_val("gameover lives", o_Lives, 0);
    check_val("gameover state", o_State, 3);
    check_val("gameover flag", o_Game_Over, 1);
    cycle(0, 0, 0, 0);
    hit();
    repeat (4) cycle(0, 0, 0, 0);
    check_val("gameover absorbing", o_State, 3);
    check_val("gameover lives held", o_Lives, 0);
    restart();
    check_val("restart lives", o_Lives, 3);
    check_val("restart level", o_Level, 0);
    check_val("restart state", o_State, 0);
    check_val("restart pulse", o_Reset_Frog, 1);
    cycle(0, 0, 0, 0);

    // Level saturation
    for (int i = 0; i < 10; i++) begin
      top();
      check_val($sformatf("levelup %0d", i), o_Level, (i + 1 > 9) ? 9 : i + 1);
      repeat (5) cycle(0, 0, 0, 0);
    end
    check_val("level saturated", o_Level, 9);
`ifdef HIGH_SCORE_EN
    check_val("best level", o_Best_Level, 9);
`endif
    restart();
    cycle(0, 0, 0, 0);
    check_val("level after restart", o_Level, 0);
`ifdef HIGH_SCORE_EN
    check_val("best kept over restart", o_Best_Level, 9);
`endif

    // Simultaneous collision and top, then restart inside DEATH
    top();
    repeat (5) cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check_val("simul state", o_State, 1);
    check_val("simul level", o_Level, 1);
    check_val("simul lives", o_Lives, 2);
    pulse_cnt = 0;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    check_val("restart in death state", o_State, 0);
    check_val("restart in death pulse", o_Reset_Frog, 1);
    repeat (12) cycle(0, 0, 1, 0);
    check_val("restart in death pulse count", pulse_cnt, 1);
    cycle(0, 0, 0, 0);

    // Async reset in the middle of LEVEL_UP
    top();
    cycle(0, 0, 0, 0);
    check_val("pre-reset state", o_State, 2);
    i_Rst = 1'b1;
    #1;
    model_reset();
    check_val("async state", o_State, 0);
    check_val("async freeze", o_Freeze, 0);
    check_val("async pulse", o_Reset_Frog, 0);
    check_model("async reset");
    pulse_cnt = 0;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    repeat (8) cycle(0, 0, 0, 0);
    check_val("no pulse after reset", pulse_cnt, 0);

    // Randomized traffic against the model
    c = 0; t = 0; r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) c = ~c;
      if ($urandom_range(0, 2) == 0) t = ~t;
      if ($urandom_range(0, 29) == 0) r = ~r;
      cycle(c, t, r, ($urandom_range(0, 499) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
